// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MFHI  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MUL   = 4'd8,
    OP_NONE  = 4'd15
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEFAULT = 5;
  localparam int MDU_DIV_CYCLES_DEFAULT  = 10;

  // Multi-cycle ops that occupy the unit and raise start/busy.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: E-stage op and operands in,
// stall/handshake and HI/LO/result out.
interface mdu_unit_if;
  logic [3:0]  sel_mdu;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (
    output sel_mdu, flush, src_a, src_b,
    input  start, busy, hi, lo, result
  );

  modport slave (
    input  sel_mdu, flush, src_a, src_b,
    output start, busy, hi, lo, result
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO compute for mult/multu/div/divu; a divide by zero
// returns the current HI/LO so the later commit leaves them unchanged.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div_s, b_div_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pend_hi = hi_cur;
    pend_lo = lo_cur;

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    prod_s  = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u  = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide done on magnitudes: truncation toward zero and a remainder
    // carrying the dividend's sign fall out, including 0x80000000 / -1.
    a_mag   = src_a[31] ? (32'd0 - src_a) : src_a;
    b_mag   = src_b[31] ? (32'd0 - src_b) : src_b;
    b_div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_div_u = (src_b == 32'd0) ? 32'd1 : src_b;
    q_s     = a_mag / b_div_s;
    r_s     = a_mag % b_div_s;
    q_u     = src_a / b_div_u;
    r_u     = src_a % b_div_u;

    case (op)
      OP_MULT:  {pend_hi, pend_lo} = prod_s;
      OP_MULTU: {pend_hi, pend_lo} = prod_u;
      OP_DIV: begin
        if (src_b != 32'd0) begin
          pend_lo = (src_a[31] ^ src_b[31]) ? (32'd0 - q_s) : q_s;
          pend_hi = src_a[31] ? (32'd0 - r_s) : r_s;
        end
      end
      OP_DIVU: begin
        if (src_b != 32'd0) begin
          pend_lo = q_u;
          pend_hi = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: issue FSM, latency counter, HI/LO and result mux.
// Define MDU_MUL_EN to decode the single-cycle three-operand mul.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  mdu_unit_if.slave bus
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] arith_hi, arith_lo;
  logic        accept, issue;

  mdu_arith u_arith (
    .op      (bus.sel_mdu),
    .src_a   (bus.src_a),
    .src_b   (bus.src_b),
    .hi_cur  (hi_q),
    .lo_cur  (lo_q),
    .pend_hi (arith_hi),
    .pend_lo (arith_lo)
  );

  assign accept = (state_q == ST_IDLE) && !bus.flush;
  assign issue  = accept && is_long_op(bus.sel_mdu);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          cnt_d     = ((bus.sel_mdu == OP_MULT) || (bus.sel_mdu == OP_MULTU))
                      ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d   = ST_BUSY;
        end else if (accept && (bus.sel_mdu == OP_MTHI)) begin
          hi_d = bus.src_a;
        end else if (accept && (bus.sel_mdu == OP_MTLO)) begin
          lo_d = bus.src_a;
        end
      end
      ST_BUSY: begin
        // Ops arriving now are ignored; the stall unit keeps them out.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    bus.result = 32'd0;
    case (bus.sel_mdu)
      OP_MFHI: bus.result = hi_q;
      OP_MFLO: bus.result = lo_q;
`ifdef MDU_MUL_EN
      OP_MUL:  bus.result = bus.src_a * bus.src_b;
`else
      OP_MUL:  bus.result = 32'd0;
`endif
      default: bus.result = 32'd0;
    endcase
  end

  assign bus.start = issue;
  assign bus.busy  = (state_q == ST_BUSY);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
